// File: rtl/adder_pkg.sv
// Shared types and constants for the ADDER feed sequencer: FSM states,
// legal kernel sizes and the kernel-size to weight-round mapping.
package adder_pkg;

    localparam int MUL_W  = 73728;
    localparam int PSUM_W = 864;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        GAP,
        DRAIN
    } state_t;

    localparam logic [3:0] WS3 = 4'd3;
    localparam logic [3:0] WS5 = 4'd5;
    localparam logic [3:0] WS7 = 4'd7;

    function automatic logic ws_legal(input logic [3:0] ws);
        return (ws == WS3) || (ws == WS5) || (ws == WS7);
    endfunction

    // Weight rounds per tile; illegal sizes map to 0 and are never latched.
    function automatic logic [2:0] rounds_of(input logic [3:0] ws);
        logic [2:0] r;
        case (ws)
            WS3:     r = 3'd1;
            WS5:     r = 3'd2;
            WS7:     r = 3'd4;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/adder_feed_ctrl_if.sv
// Product-vector intake plus ADDER-facing bus. The sequencer is the master
// of the ADDER side; the slave modport is the view from upstream/ADDER.
interface adder_feed_ctrl_if #(
    parameter int MUL_W = adder_pkg::MUL_W
);
    logic             mul_in_valid;
    logic             mul_in_ready;
    logic [MUL_W-1:0] mul_in_data;
    logic [MUL_W-1:0] MUL_results;
    logic             MUL_DATA_valid;
    logic [2:0]       wround;
    logic [3:0]       wsize;
    logic             stride;
    logic             Psum_valid;

    modport master (
        input  mul_in_valid,
        input  mul_in_data,
        input  Psum_valid,
        output mul_in_ready,
        output MUL_results,
        output MUL_DATA_valid,
        output wround,
        output wsize,
        output stride
    );

    modport slave (
        output mul_in_valid,
        output mul_in_data,
        output Psum_valid,
        input  mul_in_ready,
        input  MUL_results,
        input  MUL_DATA_valid,
        input  wround,
        input  wsize,
        input  stride
    );
endinterface

// File: rtl/adder_round_cnt.sv
// Weight-round counter: counts 0..limit while a vector is being replayed,
// with a terminal-count flag on the last round.
module adder_round_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    input  logic       clr,
    input  logic [2:0] limit,
    output logic [2:0] cnt,
    output logic       tc
);
    logic [2:0] cnt_reg;
    logic [2:0] limit_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= 3'd0;
            limit_reg <= 3'd0;
        end else if (load) begin
            cnt_reg   <= 3'd0;
            limit_reg <= limit;
        end else if (clr) begin
            cnt_reg   <= 3'd0;
        end else if (step) begin
            cnt_reg   <= cnt_reg + 3'd1;
        end
    end

    assign cnt = cnt_reg;
    assign tc  = (cnt_reg == limit_reg);

endmodule

// File: rtl/adder_feed_ctrl.sv
// Transmit-side sequencer for ADDER: accepts product vectors, replays each
// for R weight rounds with a one-cycle bubble between tiles, counts Psums.
module adder_feed_ctrl #(
    parameter int MUL_W  = 73728,
    parameter int TILE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [3:0]        cfg_wsize,
    input  logic              cfg_stride,
    input  logic [TILE_W-1:0] cfg_tiles,
    output logic              cfg_err,
    adder_feed_ctrl_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              proto_err
);
    import adder_pkg::*;

    state_t            state_reg;
    logic [TILE_W-1:0] tiles_reg;
    logic [TILE_W-1:0] issued_reg;
    logic [TILE_W-1:0] rcvd_reg;
    logic [2:0]        rounds_reg;
    logic [MUL_W-1:0]  results_reg;
    logic [3:0]        wsize_reg;
    logic              stride_reg;
    logic              data_valid_reg;
    logic              ready_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              cfg_err_reg;
    logic              proto_err_reg;

    logic              handshake;
    logic              last_round;
    logic              rc_tc;
    logic [2:0]        round_cnt;
    logic [2:0]        round_limit;
    logic [TILE_W-1:0] issued_eff;
    logic              psum_ok;
    logic              cfg_ok;

    assign handshake   = (state_reg == LOAD) && bus.mul_in_valid && ready_reg;
    assign last_round  = (state_reg == ISSUE) && rc_tc;
    assign round_limit = rounds_reg - 3'd1;
    assign cfg_ok      = ws_legal(cfg_wsize) && (cfg_tiles != '0);

    // A Psum landing in the final round of a tile belongs to that tile, so the
    // outstanding check uses the issue count as it will be after this edge.
    assign issued_eff = issued_reg + {{(TILE_W-1){1'b0}}, last_round};
    assign psum_ok    = (state_reg != IDLE) && (rcvd_reg < issued_eff);

    adder_round_cnt u_round_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (handshake),
        .step  ((state_reg == ISSUE) && !rc_tc),
        .clr   (last_round),
        .limit (round_limit),
        .cnt   (round_cnt),
        .tc    (rc_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            tiles_reg      <= '0;
            issued_reg     <= '0;
            rcvd_reg       <= '0;
            rounds_reg     <= 3'd0;
            results_reg    <= '0;
            wsize_reg      <= 4'd0;
            stride_reg     <= 1'b0;
            data_valid_reg <= 1'b0;
            ready_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            cfg_err_reg    <= 1'b0;
            proto_err_reg  <= 1'b0;
        end else begin
            cfg_err_reg <= 1'b0;
            done_reg    <= 1'b0;

            if (bus.Psum_valid) begin
                if (psum_ok) begin
                    rcvd_reg <= rcvd_reg + {{(TILE_W-1){1'b0}}, 1'b1};
                end else begin
                    proto_err_reg <= 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_ok) begin
                            wsize_reg  <= cfg_wsize;
                            stride_reg <= cfg_stride;
                            tiles_reg  <= cfg_tiles;
                            rounds_reg <= rounds_of(cfg_wsize);
                            issued_reg <= '0;
                            rcvd_reg   <= '0;
                            busy_reg   <= 1'b1;
                            ready_reg  <= 1'b1;
                            state_reg  <= LOAD;
                        end else begin
                            cfg_err_reg <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        results_reg    <= bus.mul_in_data;
                        data_valid_reg <= 1'b1;
                        ready_reg      <= 1'b0;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rc_tc) begin
                        data_valid_reg <= 1'b0;
                        issued_reg     <= issued_eff;
                        state_reg      <= (issued_eff < tiles_reg) ? GAP : DRAIN;
                    end
                end
                GAP: begin
                    ready_reg <= 1'b1;
                    state_reg <= LOAD;
                end
                DRAIN: begin
                    if (rcvd_reg == tiles_reg) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.mul_in_ready   = ready_reg;
    assign bus.MUL_results    = results_reg;
    assign bus.MUL_DATA_valid = data_valid_reg;
    assign bus.wround         = round_cnt;
    assign bus.wsize          = wsize_reg;
    assign bus.stride         = stride_reg;

    assign cfg_err   = cfg_err_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_adder_feed_ctrl.sv
// Directed bench for adder_feed_ctrl: a table of job configurations run
// through one checking task, plus reset and protocol-error sequences.
module tb_adder_feed_ctrl;
    localparam int MUL_W  = 73728;
    localparam int TILE_W = 8;

    typedef struct {
        logic [3:0] ws;
        logic [7:0] tiles;
        logic       strd;
        logic       late;
        logic       exp_err;
        int         exp_r;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_valid = 1'b0;
    logic [3:0]        cfg_wsize = 4'd0;
    logic              cfg_stride = 1'b0;
    logic [TILE_W-1:0] cfg_tiles = '0;
    logic              cfg_err;
    logic              busy;
    logic              done;
    logic              proto_err;

    int tests  = 0;
    int failed = 0;

    vec_t tbl[10];

    adder_feed_ctrl_if #(.MUL_W(MUL_W)) bus ();

    adder_feed_ctrl #(.MUL_W(MUL_W), .TILE_W(TILE_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_wsize  (cfg_wsize),
        .cfg_stride (cfg_stride),
        .cfg_tiles  (cfg_tiles),
        .cfg_err    (cfg_err),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [MUL_W-1:0] mkvec(input logic [31:0] seed);
        return {2304{seed}};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [MUL_W-1:0] act, input logic [MUL_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got low word %08h expected low word %08h", nm, act[31:0], exp[31:0]);
        end
    endtask

    task automatic chk_zero(input string nm);
        chkw({nm, "_results"}, bus.MUL_results, '0);
        chk({nm, "_valid"}, {31'd0, bus.MUL_DATA_valid}, 0);
        chk({nm, "_wround"}, {29'd0, bus.wround}, 0);
        chk({nm, "_wsize"}, {28'd0, bus.wsize}, 0);
        chk({nm, "_stride"}, {31'd0, bus.stride}, 0);
        chk({nm, "_ready"}, {31'd0, bus.mul_in_ready}, 0);
        chk({nm, "_busy"}, {31'd0, busy}, 0);
        chk({nm, "_done"}, {31'd0, done}, 0);
        chk({nm, "_cfg_err"}, {31'd0, cfg_err}, 0);
        chk({nm, "_proto_err"}, {31'd0, proto_err}, 0);
    endtask

    task automatic run_job(input vec_t v, input int row, input logic exp_proto);
        logic [MUL_W-1:0] d;
        logic             found;
        string            p;
        p = $sformatf("row%0d", row);
        cfg_valid  = 1'b1;
        cfg_wsize  = v.ws;
        cfg_tiles  = v.tiles;
        cfg_stride = v.strd;
        tick();
        cfg_valid = 1'b0;
        if (v.exp_err) begin
            chk({p, "_cfg_err_pulse"}, {31'd0, cfg_err}, 1);
            chk({p, "_err_busy"}, {31'd0, busy}, 0);
            chk({p, "_err_ready"}, {31'd0, bus.mul_in_ready}, 0);
            tick();
            chk({p, "_cfg_err_clear"}, {31'd0, cfg_err}, 0);
            chk({p, "_err_busy2"}, {31'd0, busy}, 0);
            chk({p, "_err_ready2"}, {31'd0, bus.mul_in_ready}, 0);
            $display("[TB] %s wsize=%0d tiles=%0d rejected", p, v.ws, v.tiles);
            return;
        end
        chk({p, "_cfg_err"}, {31'd0, cfg_err}, 0);
        chk({p, "_busy"}, {31'd0, busy}, 1);
        chk({p, "_ready"}, {31'd0, bus.mul_in_ready}, 1);
        chk({p, "_wsize"}, {28'd0, bus.wsize}, {28'd0, v.ws});
        chk({p, "_stride"}, {31'd0, bus.stride}, {31'd0, v.strd});
        for (int t = 0; t < int'(v.tiles); t++) begin
            d = mkvec({row[7:0], 8'h5A, t[7:0], 8'hC3});
            bus.mul_in_valid = 1'b1;
            bus.mul_in_data  = d;
            tick();
            for (int k = 0; k < v.exp_r; k++) begin
                chk($sformatf("%s_t%0d_k%0d_valid", p, t, k), {31'd0, bus.MUL_DATA_valid}, 1);
                chk($sformatf("%s_t%0d_k%0d_wround", p, t, k), {29'd0, bus.wround}, k);
                chkw($sformatf("%s_t%0d_k%0d_results", p, t, k), bus.MUL_results, d);
                chk($sformatf("%s_t%0d_k%0d_ready", p, t, k), {31'd0, bus.mul_in_ready}, 0);
                chk($sformatf("%s_t%0d_k%0d_wsize", p, t, k), {28'd0, bus.wsize}, {28'd0, v.ws});
                if (k == v.exp_r - 1 && !v.late) bus.Psum_valid = 1'b1;
                tick();
                bus.Psum_valid = 1'b0;
            end
            chk($sformatf("%s_t%0d_post_valid", p, t), {31'd0, bus.MUL_DATA_valid}, 0);
            chk($sformatf("%s_t%0d_post_wround", p, t), {29'd0, bus.wround}, 0);
            chk($sformatf("%s_t%0d_post_ready", p, t), {31'd0, bus.mul_in_ready}, 0);
            if (t < int'(v.tiles) - 1) begin
                tick();
                chk($sformatf("%s_t%0d_load_ready", p, t), {31'd0, bus.mul_in_ready}, 1);
                chk($sformatf("%s_t%0d_load_valid", p, t), {31'd0, bus.MUL_DATA_valid}, 0);
            end else begin
                bus.mul_in_valid = 1'b0;
            end
        end
        if (v.late) begin
            chk({p, "_no_early_done"}, {31'd0, done}, 0);
            for (int q = 0; q < int'(v.tiles); q++) begin
                bus.Psum_valid = 1'b1;
                tick();
                bus.Psum_valid = 1'b0;
            end
        end
        found = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk({p, "_done_seen"}, {31'd0, found}, 1);
        chk({p, "_done_busy"}, {31'd0, busy}, 0);
        chk({p, "_proto_err"}, {31'd0, proto_err}, {31'd0, exp_proto});
        tick();
        chk({p, "_done_one_cycle"}, {31'd0, done}, 0);
        $display("[TB] %s wsize=%0d tiles=%0d rounds=%0d completed", p, v.ws, v.tiles, v.exp_r);
    endtask

    initial begin
        tbl[0] = '{4'd3,  8'd1, 1'b0, 1'b0, 1'b0, 1};
        tbl[1] = '{4'd5,  8'd2, 1'b1, 1'b0, 1'b0, 2};
        tbl[2] = '{4'd7,  8'd1, 1'b0, 1'b0, 1'b0, 4};
        tbl[3] = '{4'd4,  8'd1, 1'b0, 1'b0, 1'b1, 0};
        tbl[4] = '{4'd3,  8'd0, 1'b0, 1'b0, 1'b1, 0};
        tbl[5] = '{4'd7,  8'd3, 1'b1, 1'b1, 1'b0, 4};
        tbl[6] = '{4'd5,  8'd1, 1'b0, 1'b1, 1'b0, 2};
        tbl[7] = '{4'd0,  8'd5, 1'b0, 1'b0, 1'b1, 0};
        tbl[8] = '{4'd15, 8'd1, 1'b1, 1'b0, 1'b1, 0};
        tbl[9] = '{4'd3,  8'd3, 1'b1, 1'b0, 1'b0, 1};

        bus.mul_in_valid = 1'b0;
        bus.mul_in_data  = '0;
        bus.Psum_valid   = 1'b0;

        rst = 1'b1;
        tick();
        tick();
        chk_zero("reset");
        $display("[TB] reset state checked");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_job(tbl[i], i, 1'b0);
        end

        // Stray Psum in IDLE must latch proto_err and survive a whole job.
        bus.Psum_valid = 1'b1;
        tick();
        bus.Psum_valid = 1'b0;
        chk("idle_psum_proto_err", {31'd0, proto_err}, 1);
        tick();
        chk("proto_err_sticky", {31'd0, proto_err}, 1);
        $display("[TB] idle Psum_valid raised proto_err");
        run_job(tbl[0], 20, 1'b1);

        // Abort a wsize=7 job at wround=2; a stray cfg_valid in LOAD is ignored.
        cfg_valid  = 1'b1;
        cfg_wsize  = 4'd7;
        cfg_tiles  = 8'd2;
        cfg_stride = 1'b1;
        tick();
        cfg_wsize = 4'd3;
        cfg_tiles = 8'd9;
        bus.mul_in_valid = 1'b1;
        bus.mul_in_data  = mkvec(32'hDEADBEEF);
        tick();
        cfg_valid = 1'b0;
        chk("abort_wsize_held", {28'd0, bus.wsize}, 7);
        chk("abort_no_cfg_err", {31'd0, cfg_err}, 0);
        chk("abort_wround0", {29'd0, bus.wround}, 0);
        tick();
        tick();
        chk("abort_wround2", {29'd0, bus.wround}, 2);
        chk("abort_valid", {31'd0, bus.MUL_DATA_valid}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mul_in_valid = 1'b0;
        chk_zero("abort");
        $display("[TB] reset during ISSUE checked");
        tick();
        run_job(tbl[2], 21, 1'b0);
        run_job(tbl[1], 22, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/adder_feed_ctrl.md
Name: adder_feed_ctrl

Overview:
- Transmit-side sequencer for the ADDER input interface (MUL_results / MUL_DATA_valid / wround / wsize / stride).
- Accepts multiplier-array product vectors through a valid/ready handshake and replays each vector to ADDER for the number of weight rounds required by the kernel size.
- Counts the returning Psum_valid pulses and signals job completion.

Parameters:
- MUL_W, 73728, width of one product vector (MUL_results).
- TILE_W, 8, width of the tile-count field.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- cfg_valid  in  1  start-job pulse; sampled only in IDLE
- cfg_wsize  in  4  kernel size; legal values 3, 5, 7
- cfg_stride  in  1  stride select, passed through to ADDER
- cfg_tiles  in  TILE_W  tiles in the job; legal range 1..255
- cfg_err  out  1  one-cycle pulse when a job is rejected
- mul_in_valid  in  1  upstream product vector valid
- mul_in_ready  out  1  block can accept a vector
- mul_in_data  in  MUL_W  upstream product vector
- MUL_results  out  MUL_W  registered vector to ADDER
- MUL_DATA_valid  out  1  vector valid to ADDER
- wround  out  3  current weight round
- wsize  out  4  latched kernel size
- stride  out  1  latched stride
- Psum_valid  in  1  ADDER result pulse; exactly one per tile
- busy  out  1  high from job accept until done
- done  out  1  one-cycle pulse when the job completes
- proto_err  out  1  sticky; Psum_valid seen with no tile outstanding

Behaviour:
- Reset values: all outputs 0; MUL_results 0; state IDLE; all counters 0. Reset mid-job aborts the job immediately and discards in-flight Psum counting.
- Rounds per tile, R: wsize 3 gives R=1, wsize 5 gives R=2, wsize 7 gives R=4.
- Illegal configuration: cfg_valid in IDLE with wsize not in {3,5,7}, or cfg_tiles==0.
  - cfg_err pulses on the next cycle.
  - State stays IDLE; no field is latched.
- IDLE:
  - On a legal cfg_valid, latch wsize, stride, tiles and R; set busy; go to LOAD.
  - cfg_valid outside IDLE is ignored.
- LOAD:
  - mul_in_ready=1.
  - On mul_in_valid & mul_in_ready: register mul_in_data into MUL_results, set wround=0, go to ISSUE.
- ISSUE:
  - MUL_DATA_valid=1 for exactly R consecutive cycles; wround steps 0..R-1, one per cycle.
  - MUL_results, wsize and stride stay stable throughout.
  - If the handshake occurs at edge N, MUL_DATA_valid is high in cycles N+1..N+R.
  - After the last round, issued_cnt increments.
  - If issued_cnt < tiles, go to GAP; otherwise go to DRAIN.
- GAP:
  - One cycle with MUL_DATA_valid=0 and mul_in_ready=0 (mandatory inter-tile bubble for ADDER); then go to LOAD.
- DRAIN:
  - mul_in_ready=0; wait until rcvd_cnt==tiles.
  - Then pulse done for one cycle, clear busy, go to IDLE.
- Psum_valid counting:
  - Counted in every non-IDLE state.
  - rcvd_cnt increments only while rcvd_cnt < issued_cnt.
  - A Psum_valid pulse otherwise (including in IDLE) sets proto_err and leaves the count unchanged. Only rst clears proto_err.
- Simultaneous events: Psum_valid coinciding with the last ISSUE cycle of the final tile counts normally; done still requires rcvd_cnt==tiles.
- wround is 0 whenever MUL_DATA_valid=0.
- Counters are TILE_W bits wide and never wrap, because tiles ≤ 255.

Decomposition:
- Shared package adder_pkg: state enum (IDLE, LOAD, ISSUE, GAP, DRAIN); legal wsize constants WS3=3, WS5=5, WS7=7; function rounds_of(wsize) returning R; MUL_W and PSUM_W=864 constants.
- One natural sub-module: adder_round_cnt, the wround counter with terminal-count flag, loaded with R-1.

Test Plan:
- wsize=3, tiles=1, vector A accepted at edge N → MUL_DATA_valid high cycle N+1 only with wround=0 and MUL_results=A; one Psum_valid → done pulse, busy=0.
- wsize=5, tiles=2, vectors A, B → A driven 2 cycles (wround 0,1), 1 bubble cycle, LOAD, B driven 2 cycles; two Psum_valid → one done.
- wsize=7, tiles=1 → wround 0,1,2,3 on four consecutive valid cycles; mul_in_valid held high meanwhile gives no second accept.
- cfg_wsize=4, or cfg_tiles=0 → cfg_err pulse, busy stays 0, mul_in_ready stays 0.
- Psum_valid pulsed in IDLE → proto_err=1 and remains 1 through a subsequent legal job; cleared only by rst.
- rst asserted during ISSUE of wsize=7 at wround=2 → next cycle all outputs 0, state IDLE; a new legal job then runs normally.
